// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body engine.
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10,
    DOWN  = 2'b11
  } dir_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
  } pos_t;

  localparam int POS_W = $bits(pos_t);

  localparam logic [2:0] C_APPLE = 3'b100;
  localparam logic [2:0] C_BLACK = 3'b000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_DRAW,
    S_APPLE_PICK,
    S_APPLE_DRAW,
    S_WAIT_STEP,
    S_COMPUTE,
    S_SCAN,
    S_ERASE_TAIL,
    S_DRAW_HEAD,
    S_GAME_OVER
  } state_t;

  // Opposite directions are bitwise complements in this encoding.
  function automatic logic is_opposite(dir_t a, dir_t b);
    return a == dir_t'(~b);
  endfunction

endpackage

// File: rtl/snake_body_buffer.sv
// Circular buffer of body cells; the oldest entry is the tail, the newest is the head.
module snake_body_buffer
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init_load,
  input  logic                       push,
  input  logic                       pop_tail,
  input  logic [POS_W-1:0]           push_pos,
  input  logic [$clog2(MAX_LEN)-1:0] rd_off,
  output logic [POS_W-1:0]           rd_pos,
  output logic [POS_W-1:0]           head_pos,
  output logic [POS_W-1:0]           tail_pos
);

  localparam int PTR_W = $clog2(MAX_LEN);

  pos_t             cells [MAX_LEN];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [PTR_W-1:0] head_nxt;
  logic [PTR_W-1:0] rd_ptr;

  assign head_nxt = head_ptr + PTR_W'(1);
  assign rd_ptr   = tail_ptr + rd_off;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else if (init_load) begin
      // Horizontal starting body ending at the screen centre, tail at slot 0.
      for (int k = 0; k < INIT_LEN; k++) begin
        cells[PTR_W'(k)] <= '{x: 8'(SCREEN_W/2 - (INIT_LEN-1) + k), y: 7'(SCREEN_H/2)};
      end
      tail_ptr <= '0;
      head_ptr <= PTR_W'(INIT_LEN-1);
    end else begin
      if (push) begin
        cells[head_nxt] <= push_pos;
        head_ptr        <= head_nxt;
      end
      if (pop_tail) tail_ptr <= tail_ptr + PTR_W'(1);
    end
  end

  assign rd_pos   = cells[rd_ptr];
  assign head_pos = cells[head_ptr];
  assign tail_pos = cells[tail_ptr];

endmodule

// File: rtl/snake_body_engine.sv
// Multi-cell snake game engine driving a one-pixel-per-cycle VGA plot port.
// States: IDLE wait start | INIT_DRAW plot body | APPLE_PICK sample rng | APPLE_DRAW plot apple
//   WAIT_STEP wait move | COMPUTE next head | SCAN self-hit | ERASE_TAIL | DRAW_HEAD | GAME_OVER
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int WRAP_EN  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step,
  input  logic [1:0] dir,
  input  logic [2:0] colour,
  input  logic [7:0] rng_x,
  input  logic [6:0] rng_y,
  output logic       busy,
  output logic       done,
  output logic [7:0] score,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int LEN_W = PTR_W + 1;

  localparam logic [7:0]       X_LAST    = 8'(SCREEN_W-1);
  localparam logic [7:0]       X_HI      = 8'(SCREEN_W-2);
  localparam logic [6:0]       Y_LAST    = 7'(SCREEN_H-1);
  localparam logic [6:0]       Y_HI      = 7'(SCREEN_H-2);
  localparam logic [LEN_W-1:0] LEN_INIT  = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] INIT_LAST = LEN_W'(INIT_LEN-1);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  state_t           state;
  dir_t             cur_dir;
  dir_t             eff_dir;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx;
  pos_t             apple;
  pos_t             next_head;
  logic             grow;
  logic             ate;

  pos_t rd_pos, head_pos, tail_pos;
  pos_t step_pos, wrapped;
  logic off_field;
  logic hit_apple;
  logic init_load, push, pop_tail;

  assign init_load = (state == S_IDLE) && start;
  assign push      = (state == S_DRAW_HEAD);
  assign pop_tail  = (state == S_ERASE_TAIL);

  snake_body_buffer #(
    .MAX_LEN (MAX_LEN),
    .INIT_LEN(INIT_LEN),
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_body (
    .clk      (clk),
    .rst      (rst),
    .init_load(init_load),
    .push     (push),
    .pop_tail (pop_tail),
    .push_pos (next_head),
    .rd_off   (idx[PTR_W-1:0]),
    .rd_pos   (rd_pos),
    .head_pos (head_pos),
    .tail_pos (tail_pos)
  );

  always_comb begin
    eff_dir  = is_opposite(dir_t'(dir), cur_dir) ? cur_dir : dir_t'(dir);
    step_pos = head_pos;
    case (eff_dir)
      UP:      step_pos.y = head_pos.y - 7'd1;
      LEFT:    step_pos.x = head_pos.x - 8'd1;
      RIGHT:   step_pos.x = head_pos.x + 8'd1;
      default: step_pos.y = head_pos.y + 7'd1;
    endcase
    off_field = (step_pos.x == 8'd0) || (step_pos.x == X_LAST) ||
                (step_pos.y == 7'd0) || (step_pos.y == Y_LAST);
    // Identical to step_pos whenever the move stays inside the field.
    wrapped = step_pos;
    if (step_pos.x == 8'd0)        wrapped.x = X_HI;
    else if (step_pos.x == X_LAST) wrapped.x = 8'd1;
    if (step_pos.y == 7'd0)        wrapped.y = Y_HI;
    else if (step_pos.y == Y_LAST) wrapped.y = 7'd1;
    hit_apple = (wrapped == apple);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      score     <= 8'd0;
      cur_dir   <= RIGHT;
      len       <= LEN_INIT;
      idx       <= '0;
      apple     <= '0;
      next_head <= '0;
      grow      <= 1'b0;
      ate       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          score   <= 8'd0;
          len     <= LEN_INIT;
          cur_dir <= RIGHT;
          idx     <= '0;
          state   <= S_INIT_DRAW;
        end
        S_INIT_DRAW: begin
          if (idx == INIT_LAST) state <= S_APPLE_PICK;
          else                  idx   <= idx + LEN_ONE;
        end
        S_APPLE_PICK: begin
          if (rng_x != 8'd0 && rng_x <= X_HI && rng_y != 7'd0 && rng_y <= Y_HI) begin
            apple <= '{x: rng_x, y: rng_y};
            state <= S_APPLE_DRAW;
          end
        end
        S_APPLE_DRAW: state <= S_WAIT_STEP;
        S_WAIT_STEP:  if (step) state <= S_COMPUTE;
        S_COMPUTE: begin
          cur_dir <= eff_dir;
          if (off_field && WRAP_EN == 0) begin
            done  <= 1'b1;
            state <= S_GAME_OVER;
          end else begin
            next_head <= wrapped;
            ate       <= hit_apple;
            grow      <= hit_apple && (len < LEN_MAX);
            // A non-growing move vacates the tail, so it is left out of the scan.
            idx       <= (hit_apple && (len < LEN_MAX)) ? '0 : LEN_ONE;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (rd_pos == next_head) begin
            done  <= 1'b1;
            state <= S_GAME_OVER;
          end else if (idx == len - LEN_ONE) begin
            state <= grow ? S_DRAW_HEAD : S_ERASE_TAIL;
          end else begin
            idx <= idx + LEN_ONE;
          end
        end
        S_ERASE_TAIL: state <= S_DRAW_HEAD;
        S_DRAW_HEAD: begin
          if (ate) begin
            if (score != 8'hFF) score <= score + 8'd1;
            if (grow)           len   <= len + LEN_ONE;
            state <= S_APPLE_PICK;
          end else begin
            state <= S_WAIT_STEP;
          end
        end
        S_GAME_OVER: if (!start) begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = !(state inside {S_IDLE, S_WAIT_STEP, S_GAME_OVER});
    vga_plot   = 1'b0;
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = colour;
    case (state)
      S_INIT_DRAW: begin
        vga_plot = 1'b1;
        vga_x    = rd_pos.x;
        vga_y    = rd_pos.y;
      end
      S_APPLE_DRAW: begin
        vga_plot   = 1'b1;
        vga_x      = apple.x;
        vga_y      = apple.y;
        vga_colour = C_APPLE;
      end
      S_ERASE_TAIL: begin
        vga_plot   = 1'b1;
        vga_x      = tail_pos.x;
        vga_y      = tail_pos.y;
        vga_colour = C_BLACK;
      end
      S_DRAW_HEAD: begin
        vga_plot = 1'b1;
        vga_x    = next_head.x;
        vga_y    = next_head.y;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: game-level model with expected-pixel queue plus directed scenarios.
module tb_snake_body_engine;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int ML = 32;
  localparam int IL = 3;

  logic       clk = 1'b0;
  logic       rst, start, step, w_start, w_step;
  logic [1:0] dir, w_dir;
  logic [2:0] colour;
  logic [7:0] rng_x;
  logic [6:0] rng_y;
  logic       busy, done, vga_plot;
  logic [7:0] score, vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       w_busy, w_done, w_plot;
  logic [7:0] w_score, w_x;
  logic [6:0] w_y;
  logic [2:0] w_colour;

  always #5 clk = ~clk;

  snake_body_engine #(.WRAP_EN(0)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .dir(dir), .colour(colour),
    .rng_x(rng_x), .rng_y(rng_y), .busy(busy), .done(done), .score(score),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot));

  snake_body_engine #(.WRAP_EN(1)) dut_w (
    .clk(clk), .rst(rst), .start(w_start), .step(w_step), .dir(w_dir), .colour(colour),
    .rng_x(rng_x), .rng_y(rng_y), .busy(w_busy), .done(w_done), .score(w_score),
    .vga_x(w_x), .vga_y(w_y), .vga_colour(w_colour), .vga_plot(w_plot));

  typedef struct {int x; int y; int c;} px_t;

  px_t exp_q[$];
  px_t got_q[$];
  px_t mon_g, mon_e, w_last;
  int  total = 0;
  int  bad   = 0;

  int  bx[$], by[$];
  int  mdir, mscore, ax, ay;
  bit  mover;

  function automatic px_t mk(input int x, input int y, input int c);
    px_t p;
    p.x = x; p.y = y; p.c = c;
    return p;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic pchk(input string name, input px_t g, input px_t e);
    total++;
    if (g.x != e.x || g.y != e.y || g.c != e.c) begin
      bad++;
      $display("FAIL %s: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)", name, g.x, g.y, g.c, e.x, e.y, e.c);
    end
  endtask

  always @(negedge clk) begin
    if (vga_plot) begin
      mon_g = mk(int'(vga_x), int'(vga_y), int'(vga_colour));
      got_q.push_back(mon_g);
      chk("plot_needs_busy", int'(busy), 1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_plot: got (%0d,%0d,c%0d) required no plot", mon_g.x, mon_g.y, mon_g.c);
      end else begin
        mon_e = exp_q.pop_front();
        pchk("plot_pixel", mon_g, mon_e);
      end
    end
    if (w_plot) w_last = mk(int'(w_x), int'(w_y), int'(w_colour));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet(input string nm, input bit sel_w);
    int n = 0;
    tick();
    while ((sel_w ? w_busy : busy) && n < 300) begin
      tick();
      n++;
    end
    chk(nm, int'(sel_w ? w_busy : busy), 0);
    tick();
  endtask

  task automatic m_start(input int apx, input int apy, input bit retry);
    bx.delete(); by.delete();
    for (int k = IL-1; k >= 0; k--) begin
      bx.push_back(W/2 - k);
      by.push_back(H/2);
      exp_q.push_back(mk(W/2 - k, H/2, int'(colour)));
    end
    mdir = 2; mscore = 0; mover = 0; ax = apx; ay = apy;
    if (retry) begin
      if ($urandom_range(0, 1) == 0) begin
        rng_x = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'(W-1);
        rng_y = 7'(apy);
      end else begin
        rng_x = 8'(apx);
        rng_y = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'(H-1);
      end
      start = 1'b1;
      repeat (10) tick();
      chk("retry_pending", exp_q.size(), 0);
      chk("retry_busy", int'(busy), 1);
    end
    exp_q.push_back(mk(apx, apy, 4));
    rng_x = 8'(apx);
    rng_y = 7'(apy);
    start = 1'b1;
    wait_quiet("start_timeout", 1'b0);
    chk("start_done", int'(done), 0);
    chk("start_score", int'(score), 0);
    chk("start_pending", exp_q.size(), 0);
  endtask

  task automatic do_step(input int d, input int nax, input int nay);
    int  hx, hy, nx, ny, lo;
    bit  ate, grow, hit;
    ate = 0; grow = 0; hit = 0;
    if (d + mdir != 3) mdir = d;
    hx = bx[bx.size()-1];
    hy = by[by.size()-1];
    nx = hx; ny = hy;
    case (mdir)
      0:       ny--;
      1:       nx--;
      2:       nx++;
      default: ny++;
    endcase
    if (nx < 1 || nx > W-2 || ny < 1 || ny > H-2) hit = 1;
    else begin
      ate  = (nx == ax) && (ny == ay);
      grow = ate && (bx.size() < ML);
      lo   = grow ? 0 : 1;
      for (int i = lo; i < bx.size(); i++)
        if (bx[i] == nx && by[i] == ny) hit = 1;
      if (!hit) begin
        if (!grow) begin
          exp_q.push_back(mk(bx[0], by[0], 0));
          void'(bx.pop_front());
          void'(by.pop_front());
        end
        exp_q.push_back(mk(nx, ny, int'(colour)));
        bx.push_back(nx);
        by.push_back(ny);
        if (ate) begin
          if (mscore < 255) mscore++;
          ax = nax; ay = nay;
          exp_q.push_back(mk(nax, nay, 4));
        end
      end
    end
    mover = hit;
    dir   = 2'(d);
    rng_x = 8'(nax);
    rng_y = 7'(nay);
    step  = 1'b1;
    tick();
    tick();              // second cycle of the pulse lands in COMPUTE and must be dropped
    step  = 1'b0;
    wait_quiet("step_timeout", 1'b0);
    repeat (2) tick();
    chk("step_done", int'(done), int'(mover));
    chk("step_score", int'(score), mscore);
    chk("step_pending", exp_q.size(), 0);
    chk("step_busy", int'(busy), 0);
  endtask

  task automatic end_game();
    start = 1'b0;
    tick();
    chk("idle_done", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic w_do_step(input int d);
    w_dir  = 2'(d);
    w_step = 1'b1;
    tick();
    w_step = 1'b0;
    wait_quiet("wrap_timeout", 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nax, nay, d;
    rst = 1'b1; start = 1'b0; step = 1'b0; dir = 2'b10;
    w_start = 1'b0; w_step = 1'b0; w_dir = 2'b10;
    colour = 3'b010; rng_x = 8'd0; rng_y = 7'd0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_x", int'(vga_x), 0);
    chk("rst_y", int'(vga_y), 0);
    chk("rst_colour", int'(vga_colour), int'(colour));
    rst = 1'b0;
    tick();

    // Game A: init draw, eat, straight, reversed dir, wall.
    got_q.delete();
    m_start(81, 60, 0);
    chk("a_init_n", got_q.size(), 4);
    pchk("a_init0", got_q[0], mk(78, 60, 2));
    pchk("a_init1", got_q[1], mk(79, 60, 2));
    pchk("a_init2", got_q[2], mk(80, 60, 2));
    pchk("a_apple", got_q[3], mk(81, 60, 4));
    got_q.delete();
    do_step(2, 100, 30);
    chk("a_eat_n", got_q.size(), 2);
    pchk("a_eat_head", got_q[0], mk(81, 60, 2));
    pchk("a_eat_apple", got_q[1], mk(100, 30, 4));
    chk("a_eat_score", int'(score), 1);
    got_q.delete();
    do_step(2, 100, 30);
    chk("a_move_n", got_q.size(), 2);
    pchk("a_move_erase", got_q[0], mk(78, 60, 0));
    pchk("a_move_head", got_q[1], mk(82, 60, 2));
    got_q.delete();
    do_step(1, 100, 30);
    pchk("a_rev_erase", got_q[0], mk(79, 60, 0));
    pchk("a_rev_head", got_q[1], mk(83, 60, 2));
    chk("a_rev_done", int'(done), 0);
    for (int i = 0; i < 59; i++) do_step(0, 100, 30);
    got_q.delete();
    do_step(0, 100, 30);
    chk("a_wall_done", int'(done), 1);
    chk("a_wall_plots", got_q.size(), 0);
    end_game();

    // Game B: grow to five, then turn back onto the body.
    m_start(81, 60, 0);
    do_step(2, 82, 60);
    do_step(2, 100, 30);
    chk("b_score", int'(score), 2);
    do_step(0, 100, 30);
    do_step(1, 100, 30);
    got_q.delete();
    do_step(3, 100, 30);
    chk("b_self_done", int'(done), 1);
    chk("b_self_plots", got_q.size(), 0);
    end_game();

    // Game C: length four, moving onto the cell the tail is leaving is legal.
    m_start(81, 60, 0);
    do_step(2, 100, 30);
    do_step(0, 100, 30);
    do_step(1, 100, 30);
    got_q.delete();
    do_step(3, 100, 30);
    chk("c_tail_done", int'(done), 0);
    chk("c_tail_n", got_q.size(), 2);
    pchk("c_tail_erase", got_q[0], mk(80, 60, 0));
    pchk("c_tail_head", got_q[1], mk(80, 60, 2));
    // Reset while scanning.
    dir = 2'b10;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("c_scan_busy", int'(busy), 1);
    rst = 1'b1;
    start = 1'b0;
    tick();
    chk("c_rst_busy", int'(busy), 0);
    chk("c_rst_plot", int'(vga_plot), 0);
    chk("c_rst_done", int'(done), 0);
    chk("c_rst_score", int'(score), 0);
    chk("c_rst_x", int'(vga_x), 0);
    rst = 1'b0;
    repeat (3) tick();

    // Wrap-enabled instance: run off the top edge.
    rng_x = 8'd100; rng_y = 7'd30;
    w_start = 1'b1;
    wait_quiet("wrap_start_timeout", 1'b1);
    for (int i = 0; i < 59; i++) w_do_step(0);
    pchk("w_edge_head", w_last, mk(80, 1, 2));
    w_do_step(0);
    pchk("w_wrap_head", w_last, mk(80, 118, 2));
    chk("w_wrap_done", int'(w_done), 0);
    w_do_step(0);
    pchk("w_wrap_next", w_last, mk(80, 117, 2));
    w_start = 1'b0;

    // Randomised games against the model.
    for (int g = 0; g < 8; g++) begin
      colour = 3'($urandom_range(1, 7));
      m_start(clampi(W/2 + int'($urandom_range(0, 6)) - 3, 1, W-2),
              clampi(H/2 + int'($urandom_range(0, 6)) - 3, 1, H-2), g[0]);
      for (int s = 0; s < 50 && !mover; s++) begin
        d   = ($urandom_range(0, 9) < 5) ? mdir : int'($urandom_range(0, 3));
        nax = clampi(bx[bx.size()-1] + int'($urandom_range(0, 6)) - 3, 1, W-2);
        nay = clampi(by[by.size()-1] + int'($urandom_range(0, 6)) - 3, 1, H-2);
        do_step(d, nax, nay);
      end
      if (mover) begin
        end_game();
      end else begin
        rst = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("rand_rst_busy", int'(busy), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
